// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath arithmetic blocks.
// Holds the serial-subtractor state encoding, default operand/chunk widths,
// and the sign bits that form the saturation limits for any width.
package synth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   // Saturation limits are {sign, ~sign...}: 0x7FFF.. for positive, 0x8000.. for negative.
   localparam logic SAT_POS_SIGN = 1'b0;
   localparam logic SAT_NEG_SIGN = 1'b1;

endpackage

// File: rtl/chunk_subtractor.sv
// Purpose : combinational CHUNK-bit a - b - borrow_in with borrow out.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports   : a, b (CHUNK) operands; borrow_in borrow into LSB;
//           diff (CHUNK) result mod 2^CHUNK; borrow_out 1 iff a < b + borrow_in.
module chunk_subtractor #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             borrow_in,
   output logic [CHUNK-1:0] diff,
   output logic             borrow_out
);

   // One extra bit: a negative result wraps so that the top bit is the borrow.
   logic [CHUNK:0] full;

   always_comb begin
      full       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
      diff       = full[CHUNK-1:0];
      borrow_out = full[CHUNK];
   end

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : WIDTH-bit diff = a - b - borrow_in, CHUNK bits per cycle, LSB chunk first.
// Latency : operands accepted at edge k -> out_valid in the cycle after edge k+NCHUNK.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY/DONE.
// Ports   : clk, reset (sync, active-high); in_valid/in_ready with a, b, borrow_in;
//           out_valid/out_ready with diff, borrow_out (unsigned), overflow (signed).
// Option  : SERIAL_SUBTRACTOR_SATURATE_EN clamps diff on signed overflow.
module serial_subtractor
   import synth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   // WIDTH must be an integer multiple of CHUNK.
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t            state, state_nxt;
   logic [IDXW-1:0]   idx;
   logic [WIDTH-1:0]  a_q, b_q;
   logic              borrow_q;
   logic [WIDTH-1:0]  work_q;      // partial result, never visible on diff
   logic [WIDTH-1:0]  diff_q;
   logic              borrow_out_q;
   logic              overflow_q;

   logic [CHUNK-1:0]  c_a, c_b, c_diff;
   logic              c_borrow;
   logic [WIDTH-1:0]  work_nxt;
   logic              ovf_nxt;
   logic [WIDTH-1:0]  result_nxt;

   // Single chunk slice reused every cycle; the index selects the operand slice.
   chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
      .a          (c_a),
      .b          (c_b),
      .borrow_in  (borrow_q),
      .diff       (c_diff),
      .borrow_out (c_borrow)
   );

   always_comb begin
      c_a      = a_q[idx*CHUNK +: CHUNK];
      c_b      = b_q[idx*CHUNK +: CHUNK];
      work_nxt = work_q;
      work_nxt[idx*CHUNK +: CHUNK] = c_diff;
      // Signed overflow: operand signs differ and result sign differs from a.
      ovf_nxt  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
      if (ovf_nxt) begin
         if (a_q[WIDTH-1]) begin
            result_nxt = {SAT_NEG_SIGN, {(WIDTH-1){~SAT_NEG_SIGN}}};
         end else begin
            result_nxt = {SAT_POS_SIGN, {(WIDTH-1){~SAT_POS_SIGN}}};
         end
      end else begin
         result_nxt = work_nxt;
      end
`else
      result_nxt = work_nxt;
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)        state_nxt = ST_BUSY;
         ST_BUSY: if (idx == LAST_IDX) state_nxt = ST_DONE;
         ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         borrow_q     <= 1'b0;
         work_q       <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= borrow_in;
                  idx      <= '0;
                  work_q   <= '0;
               end
            end
            ST_BUSY: begin
               work_q   <= work_nxt;
               borrow_q <= c_borrow;
               idx      <= idx + 1'b1;
               // Output register only updates on entry to DONE.
               if (idx == LAST_IDX) begin
                  diff_q       <= result_nxt;
                  borrow_out_q <= c_borrow;
                  overflow_q   <= ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready   = (state == ST_IDLE);
   assign out_valid  = (state == ST_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, scoreboard queue
// filled at stimulus time and drained by an independent output monitor.
module tb_serial_subtractor;

   typedef struct packed {
      logic [15:0] diff;
      logic        bo;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        borrow_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow_out;
   logic        overflow;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Expected result: raw modulo value, or the clamped value when saturation is built in.
   function automatic exp_t mk(input logic [15:0] raw, input logic [15:0] sat,
                               input logic bo, input logic ov);
      exp_t e;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
      e.diff = sat;
`else
      e.diff = raw;
`endif
      e.bo = bo;
      e.ov = ov;
      return e;
   endfunction

   // Monitor: one pop per completed output handshake.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got diff %h, expected no output", diff);
         end else begin
            mon_e = sb.pop_front();
            check("diff", {16'h0, diff}, {16'h0, mon_e.diff});
            check("borrow_out", {31'h0, borrow_out}, {31'h0, mon_e.bo});
            check("overflow", {31'h0, overflow}, {31'h0, mon_e.ov});
         end
      end
   end

   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                       input logic push, input exp_t ex);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL in_ready_timeout: got in_ready 0, expected 1");
      end
      a         = ta;
      b         = tb_v;
      borrow_in = tbin;
      in_valid  = 1'b1;
      if (push) sb.push_back(ex);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_in_ready",   {31'h0, in_ready},   32'd1);
      check("rst_out_valid",  {31'h0, out_valid},  32'd0);
      check("rst_diff",       {16'h0, diff},       32'h0);
      check("rst_borrow_out", {31'h0, borrow_out}, 32'd0);
      check("rst_overflow",   {31'h0, overflow},   32'd0);

      // Latency: out_valid only after the 4th edge following acceptance.
      send(16'h1234, 16'h0234, 1'b0, 1'b1, mk(16'h1000, 16'h1000, 1'b0, 1'b0));
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1 check("latency_out_valid", {31'h0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
      end
      drain();

      send(16'h0000, 16'h0001, 1'b0, 1'b1, mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0));
      send(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0001, 16'h0001, 1'b0, 1'b0));
      send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 16'h8000, 1'b0, 1'b1));
      send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, mk(16'h8000, 16'h7FFF, 1'b1, 1'b1));
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0));
      drain();

      // Backpressure: result held in DONE, new operands waiting on in_valid.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(16'h1234, 16'h0234, 1'b0, 1'b1, mk(16'h1000, 16'h1000, 1'b0, 1'b0));
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      a         = 16'h0005;
      b         = 16'h0003;
      borrow_in = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready",   {31'h0, in_ready},   32'd0);
         check("bp_out_valid",  {31'h0, out_valid},  32'd1);
         check("bp_diff",       {16'h0, diff},       32'h1000);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_hs_in_ready",  {31'h0, in_ready},  32'd1);
      check("bp_after_hs_out_valid", {31'h0, out_valid}, 32'd0);
      check("bp_result_hold",        {16'h0, diff},      32'h1000);
      sb.push_back(mk(16'h0001, 16'h0001, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      check("bp_accept_in_ready", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      drain();

      // Reset in the second BUSY cycle aborts the operation.
      send(16'h1234, 16'h0234, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0));
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("abort_in_ready",   {31'h0, in_ready},   32'd1);
      check("abort_out_valid",  {31'h0, out_valid},  32'd0);
      check("abort_diff",       {16'h0, diff},       32'h0);
      check("abort_borrow_out", {31'h0, borrow_out}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_stale", {31'h0, out_valid}, 32'd0);
      end
      send(16'h0010, 16'h0001, 1'b0, 1'b1, mk(16'h000F, 16'h000F, 1'b0, 1'b0));
      drain();

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
